// File: rtl/carpma_bolme_paketi.sv
// Constants shared by the execute-stage integer multiply and divide units.
package carpma_bolme_paketi;
  localparam int VARSAYILAN_XLEN = 32;

  localparam logic [3:0] DIV  = 4'h1;
  localparam logic [3:0] DIVU = 4'h2;
  localparam logic [3:0] REM  = 4'h4;
  localparam logic [3:0] REMU = 4'h8;

  typedef enum logic [1:0] {
    BOS    = 2'd0,
    BOL    = 2'd1,
    DUZELT = 2'd2,
    SONUC  = 2'd3
  } durum_t;

  localparam logic [VARSAYILAN_XLEN-1:0] BOLME_SIFIR_BOLUM = '1;
  localparam logic [VARSAYILAN_XLEN-1:0] ISARETLI_EN_KUCUK = 32'h8000_0000;

  function automatic logic isaretli_islem(input logic [3:0] kod);
    return (kod == DIV) || (kod == REM);
  endfunction

  function automatic logic gecerli_islem(input logic [3:0] kod);
    return (kod == DIV) || (kod == DIVU) || (kod == REM) || (kod == REMU);
  endfunction
endpackage

// File: rtl/tamsayi_bolme_birimi_if.sv
// Request/complete handshake between the execute stage and the divide unit.
interface tamsayi_bolme_birimi_if
  import carpma_bolme_paketi::*;
#(parameter int XLEN = VARSAYILAN_XLEN);
  logic [3:0]      islev_kodu_g;
  logic [XLEN-1:0] islec1_g;
  logic [XLEN-1:0] islec2_g;
  logic            hazir_g;
  logic            mesgul_c;
  logic            bitti_c;
  logic [XLEN-1:0] sonuc_c;

  modport master (
    output islev_kodu_g, islec1_g, islec2_g, hazir_g,
    input  mesgul_c, bitti_c, sonuc_c
  );

  modport slave (
    input  islev_kodu_g, islec1_g, islec2_g, hazir_g,
    output mesgul_c, bitti_c, sonuc_c
  );
endinterface

// File: rtl/kalanli_bolme_adimi.sv
// One radix-2 restoring division step on the concatenated {remainder, quotient} pair.
module kalanli_bolme_adimi #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] kalan_bolum_i,
  input  logic [XLEN-1:0]   bolen_i,
  output logic [2*XLEN-1:0] kalan_bolum_o
);
  logic [XLEN:0] kalan_kaydirilmis;
  logic [XLEN:0] deneme;

  // Remainder is always below the divisor, so XLEN+1 bits hold the shifted
  // value and the trial's top bit is exactly its sign.
  assign kalan_kaydirilmis = kalan_bolum_i[2*XLEN-1:XLEN-1];
  assign deneme            = kalan_kaydirilmis - {1'b0, bolen_i};

  always_comb begin
    kalan_bolum_o = {kalan_kaydirilmis[XLEN-1:0], kalan_bolum_i[XLEN-2:0], 1'b0};
    if (!deneme[XLEN]) begin
      kalan_bolum_o = {deneme[XLEN-1:0], kalan_bolum_i[XLEN-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/tamsayi_bolme_birimi.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock.
//   state  | meaning
//   BOS    | idle, waiting for hazir_g
//   BOL    | restoring iterations, XLEN cycles
//   DUZELT | select quotient/remainder, apply sign, register result
//   SONUC  | bitti_c pulse; a new request may be accepted here
module tamsayi_bolme_birimi
  import carpma_bolme_paketi::*;
#(
  parameter int XLEN = VARSAYILAN_XLEN
) (
  input  logic                  clk_g,
  input  logic                  rst_g,
  tamsayi_bolme_birimi_if.slave bus
);
  localparam int              SW         = $clog2(XLEN);
  localparam logic [SW-1:0]   SAYAC_BAS  = SW'(XLEN - 1);
  localparam logic [XLEN-1:0] TUM_BIR    = '1;
  localparam logic [XLEN-1:0] EN_KUCUK   = {1'b1, {(XLEN-1){1'b0}}};

  durum_t          durum_q, durum_d;
  logic [SW-1:0]   sayac_q, sayac_d;
  logic [XLEN-1:0] kalan_q, kalan_d;
  logic [XLEN-1:0] bolum_q, bolum_d;
  logic [XLEN-1:0] bolen_q, bolen_d;
  logic [3:0]      islev_q, islev_d;
  logic            bolum_isaret_q, bolum_isaret_d;
  logic            kalan_isaret_q, kalan_isaret_d;
  logic [XLEN-1:0] sonuc_q, sonuc_d;
  logic            bitti_q, bitti_d;

  logic [2*XLEN-1:0] adim_sonuc;
  logic              isaretli, isaret1, isaret2, kabul;
  logic [XLEN-1:0]   secilen;
  logic              secilen_isaret;

  kalanli_bolme_adimi #(.XLEN(XLEN)) u_adim (
    .kalan_bolum_i ({kalan_q, bolum_q}),
    .bolen_i       (bolen_q),
    .kalan_bolum_o (adim_sonuc)
  );

  always_comb begin
    durum_d        = durum_q;
    sayac_d        = sayac_q;
    kalan_d        = kalan_q;
    bolum_d        = bolum_q;
    bolen_d        = bolen_q;
    islev_d        = islev_q;
    bolum_isaret_d = bolum_isaret_q;
    kalan_isaret_d = kalan_isaret_q;
    sonuc_d        = sonuc_q;
    kabul          = 1'b0;
    isaretli       = isaretli_islem(bus.islev_kodu_g);
    isaret1        = isaretli & bus.islec1_g[XLEN-1];
    isaret2        = isaretli & bus.islec2_g[XLEN-1];
    secilen        = ((islev_q == DIV) || (islev_q == DIVU)) ? bolum_q : kalan_q;
    secilen_isaret = (islev_q == DIV) ? bolum_isaret_q : kalan_isaret_q;

    case (durum_q)
      BOS, SONUC: begin
        durum_d = BOS;
        kabul   = bus.hazir_g;
      end
      BOL: begin
        kalan_d = adim_sonuc[2*XLEN-1:XLEN];
        bolum_d = adim_sonuc[XLEN-1:0];
        sayac_d = sayac_q - 1'b1;
        if (sayac_q == '0) durum_d = DUZELT;
      end
      DUZELT: begin
        // Sign flags are only ever set for DIV/REM, so unsigned ops pass through.
        sonuc_d = secilen_isaret ? -secilen : secilen;
        durum_d = SONUC;
      end
      default: durum_d = BOS;
    endcase

    if (kabul) begin
      islev_d        = bus.islev_kodu_g;
      bolum_isaret_d = isaret1 ^ isaret2;
      kalan_isaret_d = isaret1;
      bolen_d        = isaret2 ? -bus.islec2_g : bus.islec2_g;
      bolum_d        = isaret1 ? -bus.islec1_g : bus.islec1_g;
      kalan_d        = '0;
      sayac_d        = SAYAC_BAS;
      durum_d        = BOL;
      if (!gecerli_islem(bus.islev_kodu_g)) begin
        sonuc_d = '0;
        durum_d = SONUC;
      end else if (bus.islec2_g == '0) begin
        sonuc_d = ((bus.islev_kodu_g == DIV) || (bus.islev_kodu_g == DIVU)) ?
                  TUM_BIR : bus.islec1_g;
        durum_d = SONUC;
      end else if (isaretli && (bus.islec1_g == EN_KUCUK) && (bus.islec2_g == TUM_BIR)) begin
        sonuc_d = (bus.islev_kodu_g == DIV) ? EN_KUCUK : '0;
        durum_d = SONUC;
      end
    end
  end

  assign bitti_d = (durum_d == SONUC);

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      durum_q        <= BOS;
      sayac_q        <= '0;
      kalan_q        <= '0;
      bolum_q        <= '0;
      bolen_q        <= '0;
      islev_q        <= '0;
      bolum_isaret_q <= 1'b0;
      kalan_isaret_q <= 1'b0;
      sonuc_q        <= '0;
      bitti_q        <= 1'b0;
    end else begin
      durum_q        <= durum_d;
      sayac_q        <= sayac_d;
      kalan_q        <= kalan_d;
      bolum_q        <= bolum_d;
      bolen_q        <= bolen_d;
      islev_q        <= islev_d;
      bolum_isaret_q <= bolum_isaret_d;
      kalan_isaret_q <= kalan_isaret_d;
      sonuc_q        <= sonuc_d;
      bitti_q        <= bitti_d;
    end
  end

  assign bus.mesgul_c = (durum_q == BOL) || (durum_q == DUZELT);
  assign bus.bitti_c  = bitti_q;
  assign bus.sonuc_c  = sonuc_q;
endmodule

// File: tb/tb_tamsayi_bolme_birimi.sv
// Directed and randomized checks of the divide unit against an arithmetic reference.
module tb_tamsayi_bolme_birimi;
  import carpma_bolme_paketi::*;

  logic clk_g = 1'b0;
  logic rst_g = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   dongu = 0;
  int   t0 = 0;

  tamsayi_bolme_birimi_if #(.XLEN(32)) bus();

  tamsayi_bolme_birimi #(.XLEN(32)) dut (
    .clk_g (clk_g),
    .rst_g (rst_g),
    .bus   (bus)
  );

  always #5 clk_g = ~clk_g;
  always @(posedge clk_g) dongu++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    checks++;
    assert (gozlenen === beklenen) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", etiket, gozlenen, beklenen);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] kod, input logic [31:0] a,
                                        input logic [31:0] b);
    logic tasma;
    tasma = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (kod)
      DIV:     return (b == 0) ? 32'hFFFF_FFFF : tasma ? a : 32'($signed(a) / $signed(b));
      DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:     return (b == 0) ? a : tasma ? 32'h0 : 32'($signed(a) % $signed(b));
      REMU:    return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_gecikme(input logic [3:0] kod, input logic [31:0] a,
                                       input logic [31:0] b);
    if (!((kod == DIV) || (kod == DIVU) || (kod == REM) || (kod == REMU))) return 1;
    if (b == 0) return 1;
    if (((kod == DIV) || (kod == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
      return 1;
    return 34;
  endfunction

  task automatic baslat(input logic [3:0] kod, input logic [31:0] a, input logic [31:0] b);
    bus.islev_kodu_g = kod;
    bus.islec1_g     = a;
    bus.islec2_g     = b;
    bus.hazir_g      = 1'b1;
    @(posedge clk_g); #1;
    bus.hazir_g = 1'b0;
    t0 = dongu;
  endtask

  task automatic bekle(input string etiket, output int gecikme);
    int mesgul_hata = 0;
    int sayim = 0;
    while (bus.bitti_c !== 1'b1 && sayim < 60) begin
      if (bus.mesgul_c !== 1'b1) mesgul_hata++;
      @(posedge clk_g); #1;
      sayim++;
    end
    kontrol({etiket, "_bitti_geldi"}, 32'(bus.bitti_c), 32'd1);
    kontrol({etiket, "_mesgul_suresi"}, mesgul_hata, 32'd0);
    kontrol({etiket, "_mesgul_bitti"}, 32'(bus.mesgul_c), 32'd0);
    gecikme = dongu - t0 + 1;
  endtask

  task automatic tam_islem(input string etiket, input logic [3:0] kod, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] beklenen,
                           input int bek_gecikme);
    int gecikme;
    baslat(kod, a, b);
    bekle(etiket, gecikme);
    kontrol({etiket, "_sonuc"}, bus.sonuc_c, beklenen);
    kontrol({etiket, "_gecikme"}, gecikme, bek_gecikme);
    @(posedge clk_g); #1;
    kontrol({etiket, "_bitti_tek"}, 32'(bus.bitti_c), 32'd0);
    kontrol({etiket, "_tutulan"}, bus.sonuc_c, beklenen);
  endtask

  initial begin
    int         gecikme;
    int         bitti_say;
    logic [3:0] kodlar [4];
    kodlar = '{DIV, DIVU, REM, REMU};
    bus.hazir_g      = 1'b0;
    bus.islev_kodu_g = 4'h0;
    bus.islec1_g     = 32'h0;
    bus.islec2_g     = 32'h0;

    repeat (3) @(posedge clk_g);
    #1;
    kontrol("reset_mesgul", 32'(bus.mesgul_c), 32'd0);
    kontrol("reset_bitti", 32'(bus.bitti_c), 32'd0);
    kontrol("reset_sonuc", bus.sonuc_c, 32'd0);
    @(negedge clk_g);
    rst_g = 1'b1;
    @(posedge clk_g); #1;

    tam_islem("div_100_7",     DIV,  32'd100,        32'd7,          32'd14,         34);
    tam_islem("rem_m7_2",      REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
    tam_islem("div_m7_2",      DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
    tam_islem("remu_f9_2",     REMU, 32'hFFFF_FFF9,  32'd2,          32'd1,          34);
    tam_islem("divu_ff_1",     DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34);
    tam_islem("div_5_0",       DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1);
    tam_islem("rem_5_0",       REM,  32'd5,          32'd0,          32'd5,          1);
    tam_islem("remu_min_0",    REMU, 32'h8000_0000,  32'd0,          32'h8000_0000,  1);
    tam_islem("div_tasma",     DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
    tam_islem("rem_tasma",     REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
    tam_islem("divu_tasma",    DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34);
    tam_islem("gecersiz_kod",  4'h3, 32'd100,        32'd7,          32'd0,          1);

    // Request during busy must be ignored.
    baslat(DIVU, 32'd1000, 32'd10);
    repeat (9) begin
      @(posedge clk_g); #1;
    end
    bus.islev_kodu_g = DIV;
    bus.islec1_g     = 32'd9;
    bus.islec2_g     = 32'd3;
    bus.hazir_g      = 1'b1;
    @(posedge clk_g); #1;
    bus.hazir_g = 1'b0;
    kontrol("mesgul_iken", 32'(bus.mesgul_c), 32'd1);
    bekle("mesgul_yoksay", gecikme);
    kontrol("mesgul_yoksay_sonuc", bus.sonuc_c, 32'd100);
    kontrol("mesgul_yoksay_gecikme", gecikme, 32'd34);

    // Back-to-back issue from the SONUC cycle.
    baslat(DIV, 32'd9, 32'd3);
    bekle("ardisik", gecikme);
    kontrol("ardisik_sonuc", bus.sonuc_c, 32'd3);
    kontrol("ardisik_gecikme", gecikme, 32'd34);
    @(posedge clk_g); #1;

    // Reset in the middle of an operation.
    baslat(DIV, 32'd100, 32'd7);
    repeat (14) begin
      @(posedge clk_g); #1;
    end
    kontrol("reset_oncesi_mesgul", 32'(bus.mesgul_c), 32'd1);
    #2;
    rst_g = 1'b0;
    #1;
    kontrol("reset_ortasi_mesgul", 32'(bus.mesgul_c), 32'd0);
    kontrol("reset_ortasi_bitti", 32'(bus.bitti_c), 32'd0);
    kontrol("reset_ortasi_sonuc", bus.sonuc_c, 32'd0);
    repeat (2) @(negedge clk_g);
    rst_g = 1'b1;
    bitti_say = 0;
    repeat (40) begin
      @(posedge clk_g); #1;
      if (bus.bitti_c === 1'b1) bitti_say++;
    end
    kontrol("reset_sonrasi_bitti_yok", bitti_say, 32'd0);
    tam_islem("reset_sonrasi_div", DIV, 32'd100, 32'd7, 32'd14, 34);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  kod;
      logic [31:0] a;
      logic [31:0] b;
      kod = kodlar[$urandom_range(0, 3)];
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = ISARETLI_EN_KUCUK; b = BOLME_SIFIR_BOLUM; end
        2: b = $urandom_range(1, 15);
        3: b = 32'(0 - $urandom_range(1, 15));
        4: a = $urandom_range(0, 100);
        5: kod = 4'($urandom_range(0, 15));
        default: ;
      endcase
      tam_islem("rastgele", kod, a, b, model(kod, a, b), model_gecikme(kod, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tamsayi_bolme_birimi.md
Name: tamsayi_bolme_birimi

Overview:
Iterative RV32M integer divide/remainder unit: DIV, DIVU, REM, REMU. It is the inverse-direction companion of the integer multiply unit and sits beside it in the execute stage. It uses the same request/complete handshake: `hazir_g` in, `bitti_c` out, result held on `sonuc_c`. Radix-2 restoring division, one quotient bit per clock.

Parameters:
- XLEN, 32, operand/result width. The iteration counter is clog2(XLEN) bits.

Ports:
- `clk_g`  in  1  single clock; all state updates on its rising edge.
- `rst_g`  in  1  reset, asynchronous, active-low (0 = reset).
- `islev_kodu_g`  in  4  one-hot op code: DIV=4'h1, DIVU=4'h2, REM=4'h4, REMU=4'h8.
- `islec1_g`  in  XLEN  dividend.
- `islec2_g`  in  XLEN  divisor.
- `hazir_g`  in  1  request strobe; sampled only when not busy.
- `mesgul_c`  out  1  high while a division is in progress.
- `bitti_c`  out  1  one-cycle completion pulse, registered.
- `sonuc_c`  out  XLEN  result, registered, held until the next accepted request completes.

Behaviour:
- Reset (`rst_g`=0, any time, including mid-operation):
  - state=BOS; `mesgul_c`=0, `bitti_c`=0, `sonuc_c`=0.
  - Counter, quotient and remainder registers are cleared.
  - No completion pulse is produced for the aborted operation.
- States: BOS, BOL, DUZELT, SONUC.
- BOS, or SONUC, with `hazir_g`=1 (request accepted on this edge):
  - Latch the op code.
  - Latch |dividend| and |divisor|. Absolute value is taken only for DIV/REM; DIVU/REMU use raw values.
  - Latch sign flags: quotient sign = sign1 XOR sign2; remainder sign = sign1.
  - Fast paths, resolved on the same edge, going directly to SONUC (latency 1, `bitti_c` high the next cycle):
    - Divisor 0: quotient = all ones; remainder = dividend, unmodified.
    - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
    - Op code not exactly one of the four: result 0.
  - Otherwise: go to BOL with counter = XLEN-1, remainder = 0, quotient = |dividend|.
- BOL, one iteration per cycle:
  - {rem, quo} shifted left 1.
  - Trial = rem_shifted - divisor, computed XLEN+1 bits wide.
  - If trial is non-negative, rem = trial and quo LSB = 1; else quo LSB = 0.
  - Counter decrements. Leave to DUZELT after the iteration with counter = 0 (XLEN iterations total).
- DUZELT, one cycle:
  - Result = quotient (DIV/DIVU) or remainder (REM/REMU).
  - Negate if the relevant sign flag is set and the op is signed.
  - Register into `sonuc_c`; go to SONUC.
- SONUC:
  - `bitti_c`=1 for exactly this cycle.
  - Next state is BOS, unless `hazir_g`=1, in which case the new request is accepted (back-to-back issue).
- Latency: request at edge 0 → `bitti_c` high in the cycle after edge XLEN+1, i.e. 34 cycles for XLEN=32. Fast paths take 1 cycle.
- `mesgul_c` = 1 in BOL and DUZELT. `hazir_g` during busy is ignored: no queueing, operands not re-latched.
- `sonuc_c` is unchanged from DUZELT/fast-path until the next result is written.
- Sign rules: the remainder takes the dividend's sign; quotient rounds toward zero (RISC-V semantics).

Decomposition:
- Shared package `carpma_bolme_paketi`:
  - Op-code localparams DIV/DIVU/REM/REMU.
  - XLEN default.
  - State encoding constants BOS/BOL/DUZELT/SONUC.
  - Constants BOLME_SIFIR_BOLUM (all ones) and ISARETLI_EN_KUCUK (0x80000000).
- One sub-module: `kalanli_bolme_adimi`, the combinational restoring step.
  - Inputs {rem, quo}, divisor.
  - Outputs next {rem, quo}.
  - Instantiated once and driven by the FSM. Keeps the XLEN+1 subtractor isolated for unit testing.

Test Plan:
- DIV 100 / 7 → `sonuc_c`=14; `bitti_c` pulses exactly 34 cycles after `hazir_g`; `mesgul_c` high cycles 1–33.
- REM -7 / 2 → 0xFFFFFFFF (-1). DIV -7 / 2 → 0xFFFFFFFD (-3). REMU 0xFFFFFFF9 / 2 → 1. DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF.
- Divide by zero:
  - DIV 5/0 → 0xFFFFFFFF, latency 1.
  - REM 5/0 → 5, latency 1.
  - REMU 0x80000000/0 → 0x80000000.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0; both latency 1. DIVU same operands → 0 after full 34 cycles.
- Busy/back-to-back:
  - DIVU 1000/10 issued, then `hazir_g` pulsed with 9/3 at cycle 10 → ignored; result 100.
  - `hazir_g` with 9/3 asserted in the SONUC cycle → accepted; second result 3, 34 cycles later.
- Reset mid-op: `rst_g` low at cycle 15 of DIV 100/7 → `mesgul_c`/`bitti_c`/`sonuc_c` go 0 asynchronously; no `bitti_c` afterwards; a new request after release completes normally.
